gate_analyzer: RTL and testbench

GATE_ANALYZER -- requirements
Module: gate_analyzer

---
 rtl/gate_analyzer_if.sv | 23 ++
 rtl/gate_analyzer.sv | 148 ++++++++++++++
 tb/tb_gate_analyzer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/gate_analyzer_if.sv
// Bundles the gate-under-test probe/response wires and the run control/result signals.
// The master side is the analyzer; the slave side is the environment that issues start and drives resp.
interface gate_analyzer_if;
  logic       start;
  logic       probe_a;
  logic       probe_b;
  logic       resp;
  logic       busy;
  logic       done;
  logic [3:0] truth;
  logic [5:0] match;
  logic       known;

  modport master (
    input  start, resp,
    output probe_a, probe_b, busy, done, truth, match, known
  );

  modport slave (
    output start, resp,
    input  probe_a, probe_b, busy, done, truth, match, known
  );
endinterface

// File: rtl/gate_analyzer.sv
// Walks a 2-input gate through 00,01,10,11 (SETTLE_CYCLES each) and classifies it; done pulses 4*SETTLE_CYCLES edges after start.
// No backpressure: start is ignored while busy. GATE_ANALYZER_SYNC_EN adds a 2-flop resp synchronizer (needs SETTLE_CYCLES >= 3).
module gate_analyzer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  gate_analyzer_if.master gif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] shadow_q, shadow_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pa_q, pa_d;
  logic       pb_q, pb_d;
  logic [3:0] truth_q, truth_d;
  logic [5:0] match_q, match_d;
  logic       known_q, known_d;
  logic [3:0] sh_next;
  logic       resp_s;

`ifdef GATE_ANALYZER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], gif.resp};
    end
  end

  assign resp_s = sync_q[1];
`else
  assign resp_s = gif.resp;
`endif

  function automatic logic [5:0] decode(input logic [3:0] t);
    logic [5:0] m;
    case (t)
      4'b1000: m = 6'b100000;
      4'b0111: m = 6'b010000;
      4'b1110: m = 6'b001000;
      4'b0001: m = 6'b000100;
      4'b0110: m = 6'b000010;
      4'b1001: m = 6'b000001;
      default: m = 6'b000000;
    endcase
    return m;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pa_d     = pa_q;
    pb_d     = pb_q;
    truth_d  = truth_q;
    match_d  = match_q;
    known_d  = known_q;
    sh_next  = shadow_q;
    sh_next[idx_q] = resp_s;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        // A start seen in DONE launches the next run on the same edge that ends the done pulse.
        if (gif.start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
          idx_d   = 2'd0;
          pa_d    = 1'b0;
          pb_d    = 1'b0;
        end
      end
      RUN: begin
        if (cnt_q == LAST_CNT) begin
          shadow_d = sh_next;
          cnt_d    = 8'd0;
          idx_d    = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pa_d    = 1'b0;
            pb_d    = 1'b0;
            truth_d = sh_next;
            match_d = decode(sh_next);
            known_d = |decode(sh_next);
          end else begin
            {pa_d, pb_d} = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= 2'd0;
      shadow_q <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pa_q     <= 1'b0;
      pb_q     <= 1'b0;
      truth_q  <= 4'd0;
      match_q  <= 6'd0;
      known_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pa_q     <= pa_d;
      pb_q     <= pb_d;
      truth_q  <= truth_d;
      match_q  <= match_d;
      known_q  <= known_d;
    end
  end

  assign gif.probe_a = pa_q;
  assign gif.probe_b = pb_q;
  assign gif.busy    = busy_q;
  assign gif.done    = done_q;
  assign gif.truth   = truth_q;
  assign gif.match   = match_q;
  assign gif.known   = known_q;

endmodule

// File: tb/tb_gate_analyzer.sv
// Scoreboard bench for gate_analyzer: runs push expected results, a negedge monitor pops them on done.
module tb_gate_analyzer;
`ifdef GATE_ANALYZER_SYNC_EN
  localparam int S = 3;
`else
  localparam int S = 4;
`endif
  localparam int T = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_analyzer_if gif();

  gate_analyzer #(.SETTLE_CYCLES(S)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .gif  (gif)
  );

  typedef enum int {G_AND, G_XOR, G_NOR, G_ONE, G_ANB, G_XNOR, G_NAND} gate_e;
  gate_e gate = G_AND;

  always_comb begin
    case (gate)
      G_AND:   gif.resp = gif.probe_a & gif.probe_b;
      G_XOR:   gif.resp = gif.probe_a ^ gif.probe_b;
      G_NOR:   gif.resp = ~(gif.probe_a | gif.probe_b);
      G_ONE:   gif.resp = 1'b1;
      G_ANB:   gif.resp = gif.probe_a & ~gif.probe_b;
      G_XNOR:  gif.resp = ~(gif.probe_a ^ gif.probe_b);
      G_NAND:  gif.resp = ~(gif.probe_a & gif.probe_b);
      default: gif.resp = 1'b0;
    endcase
  end

  typedef struct {
    logic [3:0] truth;
    logic [5:0] match;
    logic       known;
    longint     t;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  logic [3:0] last_truth = 4'd0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: idle probes must be 00; every done must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!gif.busy) check("idle_probes", longint'({gif.probe_a, gif.probe_b}), 0);
      if (gif.done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("truth", longint'(gif.truth), longint'(e.truth));
          check("match", longint'(gif.match), longint'(e.match));
          check("known", longint'(gif.known), longint'(e.known));
          check("done_time", longint'($time), e.t);
          last_truth = e.truth;
        end
      end
    end
  end

  task automatic push_exp(input logic [3:0] tr, input logic [5:0] m, input logic k, input longint t);
    exp_t e;
    e.truth = tr;
    e.match = m;
    e.known = k;
    e.t     = t;
    q.push_back(e);
  endtask

  // Returns at the negedge right after E0.
  task automatic start_run(input gate_e g, input logic [3:0] tr, input logic [5:0] m, input logic k);
    gate = g;
    @(negedge clk);
    gif.start = 1'b1;
    @(posedge clk);
    push_exp(tr, m, k, longint'($time) + 4 * S * T + 5);
    #1 gif.start = 1'b0;
    @(negedge clk);
    check("busy_after_start", longint'(gif.busy), 1);
    check("truth_held", longint'(gif.truth), longint'(last_truth));
  endtask

  task automatic drain();
    for (int i = 0; i < 8 * S + 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check("drain_timeout", longint'(q.size()), 0);
      q.delete();
    end
    @(negedge clk);
    check("done_one_cycle", longint'(gif.done), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},   longint'(gif.busy), 0);
    check({tag, "_done"},   longint'(gif.done), 0);
    check({tag, "_probes"}, longint'({gif.probe_a, gif.probe_b}), 0);
    check({tag, "_truth"},  longint'(gif.truth), 0);
    check({tag, "_match"},  longint'(gif.match), 0);
    check({tag, "_known"},  longint'(gif.known), 0);
  endtask

  initial begin
    longint t0;
    gif.start = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset");

    // AND, with the probe sequence and busy checked every cycle of the run.
    start_run(G_AND, 4'b1000, 6'b100000, 1'b1);
    for (int n = 0; n < 4 * S; n++) begin
      check("probe_seq", longint'({gif.probe_a, gif.probe_b}), longint'(n / S));
      check("busy_in_run", longint'(gif.busy), 1);
      @(negedge clk);
    end
    drain();

    start_run(G_XOR, 4'b0110, 6'b000010, 1'b1);
    drain();
    start_run(G_NOR, 4'b0001, 6'b000100, 1'b1);
    drain();
    start_run(G_ONE, 4'b1111, 6'b000000, 1'b0);
    drain();
    start_run(G_ANB, 4'b0100, 6'b000000, 1'b0);
    drain();

    // Start held through DONE: two back-to-back runs, second E0 is the DONE edge.
    gate = G_XNOR;
    @(negedge clk);
    gif.start = 1'b1;
    @(posedge clk);
    t0 = longint'($time);
    push_exp(4'b1001, 6'b000001, 1'b1, t0 + 4 * S * T + 5);
    push_exp(4'b1001, 6'b000001, 1'b1, t0 + (8 * S + 1) * T + 5);
    repeat (4 * S + 1) @(posedge clk);
    #1 gif.start = 1'b0;
    drain();

    // Start re-pulsed at E0+5 must be ignored.
    start_run(G_XOR, 4'b0110, 6'b000010, 1'b1);
    repeat (4) @(negedge clk);
    gif.start = 1'b1;
    @(posedge clk);
    #1 gif.start = 1'b0;
    drain();

    // Reset at E0+9 aborts the run: outputs clear immediately, no done follows.
    start_run(G_AND, 4'b1000, 6'b100000, 1'b1);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    last_truth = 4'd0;
    #1 check_zero("abort");
    repeat (6 * S) @(negedge clk);
    check("abort_no_done", longint'(gif.done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    start_run(G_NAND, 4'b0111, 6'b010000, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
